// File: rtl/mem_req_sched_pkg.sv
// Shared encodings and widths for the memory request scheduler.
package mem_req_sched_pkg;

  localparam int ADDR_W  = 22;
  localparam int DTA_W   = 64;
  localparam int OUTST_W = 4;

  typedef enum logic [1:0] {
    CMD_NOOP    = 2'd0,
    CMD_REFRESH = 2'd1,
    CMD_READ    = 2'd2,
    CMD_WRITE   = 2'd3
  } cmd_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_POP     = 2'd1,
    ST_ISSUE   = 2'd2,
    ST_REFRESH = 2'd3
  } state_e;

endpackage

// File: rtl/mem_req_outst_cnt.sv
// Outstanding-read counter: saturating up/down count plus a sticky underflow flag.
module mem_req_outst_cnt
  import mem_req_sched_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               inc_i,
  input  logic               dec_i,
  output logic [OUTST_W-1:0] cnt_o,
  output logic               err_o
);

  localparam logic [OUTST_W-1:0] CNT_ONE = OUTST_W'(1);
  localparam logic [OUTST_W-1:0] CNT_MAX = '1;

  logic [OUTST_W-1:0] cnt_q, cnt_d;
  logic               err_q, err_d;

  // Next count; a return with nothing outstanding leaves the count at zero and flags it.
  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q;
    if (inc_i && !dec_i) begin
      if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_ONE;
      else                  cnt_d = cnt_q;
    end else if (dec_i && !inc_i) begin
      if (cnt_q == '0) err_d = 1'b1;
      else             cnt_d = cnt_q - CNT_ONE;
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign cnt_o = cnt_q;
  assign err_o = err_q;

endmodule

// File: rtl/mem_req_sched.sv
// Memory request scheduler: request FIFO -> single-port memory, read data -> response FIFO.
// Optional statistics counters are enabled with the MEM_REQ_SCHED_STATS_EN define.
module mem_req_sched
  import mem_req_sched_pkg::*;
#(
  parameter int MAX_OUTST   = 4,
  parameter int REFRESH_CYC = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        mem_req_rd_cmd,
  input  logic [ADDR_W-1:0] mem_req_rd_addr,
  input  logic [DTA_W-1:0]  mem_req_rd_dta,
  output logic              mem_req_rd_en,
  input  logic              mem_req_rd_valid,
  output logic [DTA_W-1:0]  mem_res_wr_dta,
  output logic              mem_res_wr_en,
  input  logic              mem_res_wr_almost_full,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DTA_W-1:0]  mem_wdata,
  output logic              mem_re,
  output logic              mem_we,
  input  logic              mem_ready,
  input  logic [DTA_W-1:0]  mem_rdata,
  input  logic              mem_rvalid,
  output logic              sched_error
`ifdef MEM_REQ_SCHED_STATS_EN
  ,
  output logic [31:0]       stat_rd_cnt,
  output logic [31:0]       stat_wr_cnt,
  output logic [31:0]       stat_stall_cnt
`endif
);

  localparam int                 REF_W    = 16;
  localparam logic [REF_W-1:0]   REF_LOAD = REF_W'(REFRESH_CYC - 1);
  localparam logic [OUTST_W-1:0] MAX_Q    = OUTST_W'(MAX_OUTST);

  state_e             state_q;
  logic               run_q;
  logic               re_q, we_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [DTA_W-1:0]   wdata_q;
  logic [REF_W-1:0]   ref_cnt_q;
  logic               res_en_q;
  logic [DTA_W-1:0]   res_dta_q;
  logic [OUTST_W-1:0] outst_s;
  logic               allowed_s;
  logic               rd_acc_s;
  cmd_e               cmd_s;

  // run_q keeps the pop strobe low while reset is held even though IDLE is the reset state.
  assign allowed_s     = !mem_res_wr_almost_full && (outst_s < MAX_Q);
  assign mem_req_rd_en = run_q && (state_q == ST_IDLE) && allowed_s;
  assign rd_acc_s      = (state_q == ST_ISSUE) && re_q && mem_ready;
  assign cmd_s         = cmd_e'(mem_req_rd_cmd);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      run_q     <= 1'b0;
      re_q      <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      ref_cnt_q <= '0;
    end else begin
      run_q <= 1'b1;
      case (state_q)
        ST_IDLE: begin
          if (mem_req_rd_en) state_q <= ST_POP;
        end
        ST_POP: begin
          if (!mem_req_rd_valid) begin
            state_q <= ST_IDLE;
          end else begin
            case (cmd_s)
              CMD_REFRESH: begin
                state_q   <= ST_REFRESH;
                ref_cnt_q <= REF_LOAD;
              end
              CMD_READ: begin
                state_q <= ST_ISSUE;
                re_q    <= 1'b1;
                addr_q  <= mem_req_rd_addr;
              end
              CMD_WRITE: begin
                state_q <= ST_ISSUE;
                we_q    <= 1'b1;
                addr_q  <= mem_req_rd_addr;
                wdata_q <= mem_req_rd_dta;
              end
              default: state_q <= ST_IDLE;
            endcase
          end
        end
        ST_ISSUE: begin
          if (mem_ready) begin
            re_q    <= 1'b0;
            we_q    <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        ST_REFRESH: begin
          if (ref_cnt_q == '0) state_q <= ST_IDLE;
          else                 ref_cnt_q <= ref_cnt_q - 16'd1;
        end
        default: begin
          state_q <= ST_IDLE;
          re_q    <= 1'b0;
          we_q    <= 1'b0;
        end
      endcase
    end
  end

  // Read returns are never stalled; they are forwarded one cycle after mem_rvalid.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      res_en_q  <= 1'b0;
      res_dta_q <= '0;
    end else begin
      res_en_q <= mem_rvalid;
      if (mem_rvalid) res_dta_q <= mem_rdata;
    end
  end

  mem_req_outst_cnt u_outst (
    .clk   (clk),
    .rst   (rst),
    .inc_i (rd_acc_s),
    .dec_i (mem_rvalid),
    .cnt_o (outst_s),
    .err_o (sched_error)
  );

  assign mem_addr       = addr_q;
  assign mem_wdata      = wdata_q;
  assign mem_re         = re_q;
  assign mem_we         = we_q;
  assign mem_res_wr_en  = res_en_q;
  assign mem_res_wr_dta = res_dta_q;

`ifdef MEM_REQ_SCHED_STATS_EN
  logic        wr_acc_s;
  logic [31:0] rd_cnt_q, wr_cnt_q, stall_cnt_q;

  assign wr_acc_s = (state_q == ST_ISSUE) && we_q && mem_ready;

  // Event counters wrap naturally at 2^32.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_cnt_q    <= 32'd0;
      wr_cnt_q    <= 32'd0;
      stall_cnt_q <= 32'd0;
    end else begin
      if (rd_acc_s) rd_cnt_q <= rd_cnt_q + 32'd1;
      if (wr_acc_s) wr_cnt_q <= wr_cnt_q + 32'd1;
      if (run_q && (state_q == ST_IDLE) && !allowed_s) stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign stat_rd_cnt    = rd_cnt_q;
  assign stat_wr_cnt    = wr_cnt_q;
  assign stat_stall_cnt = stall_cnt_q;
`endif

endmodule
